mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter for the single data-memory port (address/load/in/out/busy) of the Memory block.
- Master 0 is the CPU. Master 1 is a secondary requester, e.g. a debug/loader engine that pokes RAM or the screen buffer.
- Serialises accesses and honours the memory's busy stall.
- Fixed priority to master 0, with a starvation guard so master 1 always makes progress.

Parameters:
- ADDR_W, 16, address width of masters and memory port
- DATA_W, 16, data width
- MAX_STARVE, 4, consecutive master-0 grants allowed while master 1 waits; 1..15
- TIMEOUT, 255, WAIT cycles before abort (only with MEM_ARB_TIMEOUT_EN); 1..255

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_write  in  1  1 = write, 0 = read; stable while m0_req
- m0_address  in  ADDR_W  target address
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data; valid with m0_ack, held until next m0_ack
- m1_req, m1_write, m1_address, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- mem_address  out  ADDR_W  to Memory address
- mem_wdata  out  DATA_W  to Memory in
- mem_load  out  1  to Memory load
- mem_rdata  in  DATA_W  from Memory out
- mem_busy  in  1  from Memory busy
- owner  out  1  master owning the current/last transaction
- timeout_err  out  1  sticky abort flag (macro only)

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0, including rdata registers and owner; starve_cnt=0. An in-flight access is abandoned and mem_load drops the same instant.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration on sampled requests:
  - Only one req high: grant it.
  - Both high: grant m1 if starve_cnt==MAX_STARVE, else m0.
  - On grant, latch address/wdata/write into mem_address/mem_wdata/wr_q and set owner. Go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle): mem_load=wr_q. Go to WAIT.
- WAIT: mem_load=0; mem_address and mem_wdata held.
  - mem_busy==1: stay.
  - mem_busy==0: capture mem_rdata into owner's rdata register (reads only; writes leave rdata unchanged). Go to DONE.
- DONE (1 cycle): the owner's ack is high. Go to IDLE.
- Latency: req high at IDLE edge N, mem_busy low throughout -> ack high in cycle N+3. Each cycle mem_busy is high adds one cycle.
- Back-to-back: a requester holding req after ack is re-arbitrated in IDLE. Minimum 4 cycles per access.
- starve_cnt:
  - Increments, saturating at MAX_STARVE, on each m0 grant made while m1_req is high.
  - Clears on any m1 grant.
  - Holds when m1_req is low.
- mem_address and mem_wdata keep their last value in IDLE. mem_load is high only in ISSUE and only for writes.
- A requester dropping req before ack is a protocol violation. The transaction still completes and ack still pulses.
- The ack of the non-owner stays 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and counts WAIT cycles.
  - If it reaches TIMEOUT while mem_busy is still 1: go to DONE, ack the owner with rdata forced to 0, and set timeout_err.
  - timeout_err is sticky; cleared only by reset.
- Undefined:
  - WAIT has no limit; the timeout_err port is absent.

Test Plan:
- Single read: m0 read addr 0x4000, mem_rdata=0x1234, busy never high -> mem_load=0 throughout; m0_ack at cycle N+3; m0_rdata=0x1234.
- Write with stall: m1 write 0x0010←0xBEEF, mem_busy high 5 cycles in WAIT -> mem_load high exactly 1 cycle; mem_address=0x0010 and mem_wdata=0xBEEF held; m1_ack at N+8.
- Contention: both masters request continuously, MAX_STARVE=4 -> grant sequence m0,m0,m0,m0,m1 repeating; m1 is never starved beyond 4.
- Simultaneous after reset: m0 and m1 both request in the first cycle -> m0 granted first; owner=0, then owner=1.
- Reset mid-WAIT: assert reset with busy high -> mem_load, acks, owner and rdata are 0 immediately; state IDLE after release; a fresh request completes normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8, mem_busy stuck high -> ack after 8 WAIT cycles; rdata=0; timeout_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of the single data-memory port.
//   Master 0 (CPU) has fixed priority. Master 1 is granted after MAX_STARVE
//   consecutive master-0 grants made while it was waiting.
//   Latency: req sampled in IDLE at edge N -> ack high in the cycle after edge N+2
//   (+1 cycle per mem_busy stall cycle). Minimum 4 cycles per access.
//   Backpressure: mem_busy holds the arbiter in WAIT. Requesters wait for ack.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_* / m1_*                req/write/address/wdata in, ack pulse/rdata out
//   mem_address/mem_wdata      latched on grant, held until the next grant
//   mem_load                   write strobe, high for the single ISSUE cycle
//   mem_rdata/mem_busy         memory read data and stall
//   owner                      master owning the current/last transaction
//   timeout_err                sticky WAIT-timeout flag (MEM_ARB_TIMEOUT_EN only)
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   Aborts WAIT after TIMEOUT busy cycles. Acks the owner with rdata 0.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  output logic              owner
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  if (MAX_STARVE < 1 || MAX_STARVE > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("mem_arbiter: MAX_STARVE must be 1..15 and TIMEOUT 1..255");
  end

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       wr_q;
  logic [3:0] starve_cnt;
  logic       grant;
  logic       grant_m1;
  logic       wait_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
`endif

  // Next-state and grant decision.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_m1  = 1'b0;
    wait_done = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant     = 1'b1;
          // m1 wins when alone, or when m0 has used up its consecutive grants.
          grant_m1  = m1_req && (!m0_req || starve_cnt == STARVE_LIM);
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!mem_busy) begin
          wait_done = 1'b1;
          state_nxt = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Counter holds completed busy cycles. Abort on the TIMEOUT-th one.
        else if (tmo_cnt == TMO_LIM) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      wr_q        <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      starve_cnt  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner       <= grant_m1;
        wr_q        <= grant_m1 ? m1_write   : m0_write;
        mem_address <= grant_m1 ? m1_address : m0_address;
        mem_wdata   <= grant_m1 ? m1_wdata   : m0_wdata;
        // Only m0 grants that overtake a waiting m1 count toward starvation.
        if (grant_m1) begin
          starve_cnt <= '0;
        end else if (m1_req && starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
      if (wait_done && !wr_q) begin
        if (owner) begin
          m1_rdata <= mem_rdata;
        end else begin
          m0_rdata <= mem_rdata;
        end
      end
`ifdef MEM_ARB_TIMEOUT_EN
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
        if (owner) begin
          m1_rdata <= '0;
        end else begin
          m0_rdata <= '0;
        end
      end
`endif
    end
  end

  // Decoded from state so that reset clears them immediately.
  assign mem_load = (state == ISSUE) && wr_q;
  assign m0_ack   = (state == DONE) && !owner;
  assign m1_ack   = (state == DONE) && owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-timeline model.
//   The model tracks grant/complete edge numbers and the expected register contents.
//   Outputs are compared on every falling edge. Literal checks pin the model.
module tb_mem_arbiter;
  localparam int MAX_STARVE = 4;
  localparam int TIMEOUT    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [15:0] m0_address = '0, m0_wdata = '0;
  logic        m0_ack;
  logic [15:0] m0_rdata;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [15:0] m1_address = '0, m1_wdata = '0;
  logic        m1_ack;
  logic [15:0] m1_rdata;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_load;
  logic [15:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;
  logic        owner;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_load(mem_load),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .owner(owner)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int          cyc = 0;        // rising edges counted outside reset
  bit          in_txn = 1'b0;
  bit          done_valid = 1'b0;
  int          g_edge = 0;     // edge at which the current transaction was granted
  int          done_edge = 0;  // edge at which the memory finished it
  int          free_at = 1;    // first edge at which a new grant may be made
  logic        m_own = 1'b0, m_wr = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0;
  logic [15:0] m_rd [2] = '{16'h0, 16'h0};
  int          starve = 0;
  logic        m_err = 1'b0;
  bit          p1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      in_txn = 1'b0; done_valid = 1'b0;
      m_own = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
      m_rd[0] = '0; m_rd[1] = '0; starve = 0; m_err = 1'b0;
      free_at = cyc + 1;
    end else begin
      cyc++;
      if (in_txn) begin
        // Memory result is sampled from two edges after the grant onward.
        if (cyc >= g_edge + 2) begin
          if (!mem_busy) begin
            if (!m_wr) m_rd[m_own] = mem_rdata;
            in_txn = 1'b0; done_valid = 1'b1; done_edge = cyc; free_at = cyc + 2;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cyc == g_edge + 1 + TIMEOUT) begin
            m_rd[m_own] = '0; m_err = 1'b1;
            in_txn = 1'b0; done_valid = 1'b1; done_edge = cyc; free_at = cyc + 2;
          end
`endif
        end
      end else if (cyc >= free_at && (m0_req || m1_req)) begin
        p1 = m1_req && (!m0_req || starve == MAX_STARVE);
        if (p1) starve = 0;
        else if (m1_req && starve < MAX_STARVE) starve = starve + 1;
        m_own   = p1;
        m_wr    = p1 ? m1_write : m0_write;
        m_addr  = p1 ? m1_address : m0_address;
        m_wdata = p1 ? m1_wdata : m0_wdata;
        g_edge  = cyc;
        in_txn  = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("mem_load", mem_load, in_txn && m_wr && cyc == g_edge);
    chk("m0_ack", m0_ack, done_valid && cyc == done_edge && !m_own);
    chk("m1_ack", m1_ack, done_valid && cyc == done_edge && m_own);
    chk("owner", owner, m_own);
    chk("mem_address", mem_address, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("m0_rdata", m0_rdata, m_rd[0]);
    chk("m1_rdata", m1_rdata, m_rd[1]);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err, m_err);
`endif
  end

  // Observation log: which master was acked, owner at ack, ack edge, strobe count.
  int ack_log[$];
  int own_log[$];
  int ack_edge = 0;
  int load_cycles = 0;

  always @(negedge clk) begin
    if (mem_load) load_cycles++;
    if (m0_ack || m1_ack) begin
      ack_log.push_back(m1_ack ? 1 : 0);
      own_log.push_back(int'(owner));
      ack_edge = cyc + 1;  // the rising edge that samples this ack
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k = 0;
    while (ack_log.size() < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("ack_wait_bound", ack_log.size() >= target, 1'b1);
  endtask

  int n_edge;
  int base;
  int lc0;
  int exp_seq[10];

  initial begin
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    repeat (3) tick();
    chk("rst_mem_load", mem_load, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 16'h0);
    chk("rst_mem_address", mem_address, 16'h0);
    reset = 1'b0;
    tick();

    // Single read, no stall.
    base = ack_log.size(); lc0 = load_cycles;
    mem_rdata = 16'h1234; mem_busy = 1'b0;
    n_edge = cyc + 1; m0_write = 1'b0; m0_address = 16'h4000; m0_req = 1'b1;
    wait_acks(base + 1, 20);
    m0_req = 1'b0;
    chk("rd_latency", ack_edge - n_edge, 3);
    chk("rd_m0_rdata", m0_rdata, 16'h1234);
    chk("rd_owner", owner, 1'b0);
    tick(); tick();
    chk("rd_no_load", load_cycles - lc0, 0);

    // Write from m1 with a five-cycle stall in WAIT.
    base = ack_log.size(); lc0 = load_cycles;
    mem_busy = 1'b1;
    n_edge = cyc + 1; m1_write = 1'b1; m1_address = 16'h0010; m1_wdata = 16'hBEEF; m1_req = 1'b1;
    while (cyc < n_edge + 6) tick();
    mem_busy = 1'b0;
    wait_acks(base + 1, 20);
    m1_req = 1'b0;
    chk("wr_latency", ack_edge - n_edge, 8);
    chk("wr_load_cycles", load_cycles - lc0, 1);
    chk("wr_mem_address", mem_address, 16'h0010);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr_m1_rdata_kept", m1_rdata, 16'h0);
    chk("wr_m0_rdata_kept", m0_rdata, 16'h1234);
    tick(); tick();
    m1_write = 1'b0;

    // Both request in the first cycle after reset.
    reset = 1'b1; tick(); tick();
    base = ack_log.size();
    mem_rdata = 16'h00AA;
    m0_address = 16'h0100; m1_address = 16'h0200;
    m0_req = 1'b1; m1_req = 1'b1; reset = 1'b0;
    wait_acks(base + 1, 20);
    m0_req = 1'b0;
    wait_acks(base + 2, 20);
    m1_req = 1'b0;
    if (ack_log.size() >= base + 2) begin
      chk("sim_first_ack", ack_log[base], 0);
      chk("sim_second_ack", ack_log[base + 1], 1);
      chk("sim_first_owner", own_log[base], 0);
      chk("sim_second_owner", own_log[base + 1], 1);
    end
    chk("sim_m1_rdata", m1_rdata, 16'h00AA);
    tick(); tick();

    // Continuous contention: four m0 grants, then one m1 grant, repeating.
    base = ack_log.size();
    mem_rdata = 16'h5555;
    m0_req = 1'b1; m1_req = 1'b1;
    wait_acks(base + 10, 100);
    m0_req = 1'b0; m1_req = 1'b0;
    if (ack_log.size() >= base + 10) begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("grant_seq%0d", i), ack_log[base + i], exp_seq[i]);
    end
    tick(); tick();

    // Reset asserted mid-WAIT with the memory busy.
    mem_busy = 1'b1;
    n_edge = cyc + 1; m1_write = 1'b1; m1_address = 16'h0777; m1_wdata = 16'h0ABC; m1_req = 1'b1;
    while (cyc < n_edge + 3) tick();
    chk("pre_rst_owner", owner, 1'b1);
    chk("pre_rst_m0_rdata", m0_rdata, 16'h5555);
    #1 reset = 1'b1;
    #1;
    chk("midrst_mem_load", mem_load, 1'b0);
    chk("midrst_m0_ack", m0_ack, 1'b0);
    chk("midrst_m1_ack", m1_ack, 1'b0);
    chk("midrst_owner", owner, 1'b0);
    chk("midrst_m0_rdata", m0_rdata, 16'h0);
    chk("midrst_m1_rdata", m1_rdata, 16'h0);
    chk("midrst_mem_address", mem_address, 16'h0);
    m1_req = 1'b0; m1_write = 1'b0; mem_busy = 1'b0;
    tick(); reset = 1'b0; tick();

    // Reset during the ISSUE cycle of a write drops mem_load at once.
    m0_write = 1'b1; m0_address = 16'h2222; m0_wdata = 16'h3333; m0_req = 1'b1;
    tick();
    chk("issue_load", mem_load, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("issue_rst_load", mem_load, 1'b0);
    m0_req = 1'b0; m0_write = 1'b0;
    tick(); reset = 1'b0; tick();

    // A fresh read after reset completes normally.
    base = ack_log.size();
    mem_rdata = 16'h0F0F;
    n_edge = cyc + 1; m0_address = 16'h0042; m0_req = 1'b1;
    wait_acks(base + 1, 20);
    m0_req = 1'b0;
    chk("fresh_latency", ack_edge - n_edge, 3);
    chk("fresh_m0_rdata", m0_rdata, 16'h0F0F);
    tick(); tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory stuck busy: abort after TIMEOUT WAIT cycles.
    base = ack_log.size();
    mem_busy = 1'b1; mem_rdata = 16'hFFFF;
    n_edge = cyc + 1; m0_address = 16'h0050; m0_req = 1'b1;
    wait_acks(base + 1, 40);
    m0_req = 1'b0;
    chk("tmo_latency", ack_edge - n_edge, 2 + TIMEOUT);
    chk("tmo_rdata", m0_rdata, 16'h0);
    chk("tmo_err", timeout_err, 1'b1);
    mem_busy = 1'b0;
    repeat (5) tick();
    chk("tmo_err_sticky", timeout_err, 1'b1);
    reset = 1'b1; tick();
    chk("tmo_err_rst", timeout_err, 1'b0);
    reset = 1'b0; tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
